// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester PicoRV32 native memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
  } mem_rsp_t;

  localparam logic [31:0] MEM_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// PicoRV32 native memory bus: the master issues requests, the slave answers with ready/rdata.
interface mem_bus_if;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to the one != last.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       any,
  output logic       pick
);

  always_comb begin
    any  = |valid;
    pick = (valid == 2'b11) ? ~last : valid[1];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native-bus target between two requesters, with a watchdog
// that aborts unacknowledged transactions and returns ERR_DATA.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = MEM_ERR_DATA
) (
  input  logic      clk,
  input  logic      reset,
  mem_bus_if.slave  m0,
  mem_bus_if.slave  m1,
  mem_bus_if.master s,
  output logic      grant,
  output logic      timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  arb_state_t    state;
  logic          last;
  logic [CW-1:0] cnt;
  logic          any;
  logic          pick;
  mem_req_t      req0, req1, req_sel;
  mem_rsp_t      rsp_g;

  rr_arbiter2 u_rr (
    .valid ({m1.mem_valid, m0.mem_valid}),
    .last  (last),
    .any   (any),
    .pick  (pick)
  );

  always_comb begin
    req0    = '{valid: m0.mem_valid, instr: m0.mem_instr, addr: m0.mem_addr,
                wdata: m0.mem_wdata, wstrb: m0.mem_wstrb};
    req1    = '{valid: m1.mem_valid, instr: m1.mem_instr, addr: m1.mem_addr,
                wdata: m1.mem_wdata, wstrb: m1.mem_wstrb};
    req_sel = grant ? req1 : req0;
  end

  // Everything downstream is gated by state so an async reset zeroes outputs at once.
  always_comb begin
    s.mem_valid = 1'b0;
    s.mem_instr = 1'b0;
    s.mem_addr  = '0;
    s.mem_wdata = '0;
    s.mem_wstrb = '0;
    rsp_g       = '0;
    timeout_err = 1'b0;
    unique case (state)
      BUSY: begin
        s.mem_valid = req_sel.valid;
        s.mem_instr = req_sel.instr;
        s.mem_addr  = req_sel.addr;
        s.mem_wdata = req_sel.wdata;
        s.mem_wstrb = req_sel.wstrb;
        rsp_g       = '{ready: s.mem_ready, rdata: s.mem_rdata};
      end
      ERR: begin
        rsp_g       = '{ready: 1'b1, rdata: ERR_DATA};
        timeout_err = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    m0.mem_ready = grant ? 1'b0 : rsp_g.ready;
    m0.mem_rdata = grant ? '0   : rsp_g.rdata;
    m1.mem_ready = grant ? rsp_g.ready : 1'b0;
    m1.mem_rdata = grant ? rsp_g.rdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            grant <= pick;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (s.mem_ready) begin
            last  <= grant;
            state <= IDLE;
          end else if (!req_sel.valid) begin
            state <= IDLE;
          end else if (TIMEOUT != 0) begin
            // cnt holds completed unacknowledged cycles; abort at the end of the TIMEOUT-th.
            if (cnt == LIM) state <= ERR;
            else            cnt   <= cnt + CW'(1);
          end
        end
        ERR: begin
          last  <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT=8); inputs change and outputs are
// checked just after each falling edge.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic grant;
  logic timeout_err;
  int   n_assert = 0;
  int   n_fail   = 0;

  mem_bus_if m0_if ();
  mem_bus_if m1_if ();
  mem_bus_if s_if ();

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; callers drive inputs, then settle() before checking.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_if.mem_valid = 0; m0_if.mem_instr = 0; m0_if.mem_addr = 0;
    m0_if.mem_wdata = 0; m0_if.mem_wstrb = 0;
    m1_if.mem_valid = 0; m1_if.mem_instr = 0; m1_if.mem_addr = 0;
    m1_if.mem_wdata = 0; m1_if.mem_wstrb = 0;
    s_if.mem_ready = 0; s_if.mem_rdata = 0;

    // Reset state
    step(); step(); settle();
    chk1("rst_s_valid", s_if.mem_valid, 1'b0);
    chk1("rst_grant", grant, 1'b0);
    chk1("rst_m0_ready", m0_if.mem_ready, 1'b0);
    chk1("rst_m1_ready", m1_if.mem_ready, 1'b0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b0;

    // 1: m0 read 0x100, target ready on the 3rd BUSY cycle
    step(); m0_if.mem_valid = 1; m0_if.mem_addr = 32'h100; settle();
    chk1("t1_idle_s_valid", s_if.mem_valid, 1'b0);
    step(); settle();
    chk1("t1_s_valid", s_if.mem_valid, 1'b1);
    chk32("t1_s_addr", s_if.mem_addr, 32'h100);
    chk1("t1_grant", grant, 1'b0);
    chk1("t1_m0_ready_early", m0_if.mem_ready, 1'b0);
    step(); settle();
    chk1("t1_m0_ready_wait", m0_if.mem_ready, 1'b0);
    step(); s_if.mem_ready = 1; s_if.mem_rdata = 32'h1234_5678; settle();
    chk1("t1_m0_ready", m0_if.mem_ready, 1'b1);
    chk32("t1_m0_rdata", m0_if.mem_rdata, 32'h1234_5678);
    chk1("t1_m1_ready", m1_if.mem_ready, 1'b0);
    step(); m0_if.mem_valid = 0; s_if.mem_ready = 0; s_if.mem_rdata = 0; settle();
    chk1("t1_m0_ready_pulse", m0_if.mem_ready, 1'b0);
    chk1("t1_s_valid_after", s_if.mem_valid, 1'b0);

    // 2: simultaneous requests right after reset -> m0 first, then m1
    step(); reset = 1; settle();
    step(); reset = 0;
    m0_if.mem_valid = 1; m0_if.mem_addr = 32'h10;
    m1_if.mem_valid = 1; m1_if.mem_addr = 32'h20; settle();
    chk1("t2_idle_s_valid", s_if.mem_valid, 1'b0);
    step(); s_if.mem_ready = 1; settle();
    chk1("t2_first_grant", grant, 1'b0);
    chk32("t2_first_addr", s_if.mem_addr, 32'h10);
    chk1("t2_m0_ready", m0_if.mem_ready, 1'b1);
    chk1("t2_m1_ready_blocked", m1_if.mem_ready, 1'b0);
    step(); m0_if.mem_valid = 0; s_if.mem_ready = 0; settle();
    chk1("t2_gap_s_valid", s_if.mem_valid, 1'b0);
    step(); s_if.mem_ready = 1; settle();
    chk1("t2_second_grant", grant, 1'b1);
    chk32("t2_second_addr", s_if.mem_addr, 32'h20);
    chk1("t2_m1_ready", m1_if.mem_ready, 1'b1);
    chk1("t2_m0_ready_blocked", m0_if.mem_ready, 1'b0);
    step(); s_if.mem_ready = 0; settle();

    // 3: both continuously valid, ready on 2nd BUSY cycle -> grants 0,1,0,1
    m0_if.mem_valid = 1; m1_if.mem_valid = 1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin
        step(); s_if.mem_ready = 0; settle();
      end
      chk1("t3_idle_s_valid", s_if.mem_valid, 1'b0);
      step(); settle();
      chk1("t3_grant", grant, i[0]);
      chk1("t3_s_valid", s_if.mem_valid, 1'b1);
      step(); s_if.mem_ready = 1; settle();
      chk1("t3_granted_ready", i[0] ? m1_if.mem_ready : m0_if.mem_ready, 1'b1);
      chk1("t3_other_ready", i[0] ? m0_if.mem_ready : m1_if.mem_ready, 1'b0);
    end
    step(); s_if.mem_ready = 0; m0_if.mem_valid = 0; m1_if.mem_valid = 0; settle();

    // 4: m1 write forwarded exactly
    step();
    m1_if.mem_valid = 1; m1_if.mem_instr = 1; m1_if.mem_addr = 32'h200;
    m1_if.mem_wdata = 32'hCAFE_F00D; m1_if.mem_wstrb = 4'hF; settle();
    step(); settle();
    chk1("t4_grant", grant, 1'b1);
    chk1("t4_s_valid", s_if.mem_valid, 1'b1);
    chk1("t4_s_instr", s_if.mem_instr, 1'b1);
    chk32("t4_s_addr", s_if.mem_addr, 32'h200);
    chk32("t4_s_wdata", s_if.mem_wdata, 32'hCAFE_F00D);
    chk32("t4_s_wstrb", {28'd0, s_if.mem_wstrb}, 32'hF);
    step(); s_if.mem_ready = 1; settle();
    chk1("t4_m1_ready", m1_if.mem_ready, 1'b1);
    chk1("t4_m0_ready", m0_if.mem_ready, 1'b0);
    chk32("t4_m0_rdata", m0_if.mem_rdata, 32'h0);
    step(); s_if.mem_ready = 0; m1_if.mem_valid = 0; m1_if.mem_instr = 0;
    m1_if.mem_wstrb = 0; settle();

    // 5: target never ready -> abort after 8 BUSY cycles
    step(); m0_if.mem_valid = 1; m0_if.mem_addr = 32'h300; settle();
    for (int i = 0; i < 8; i++) begin
      step(); settle();
      chk1("t5_busy_s_valid", s_if.mem_valid, 1'b1);
      chk1("t5_busy_ready", m0_if.mem_ready, 1'b0);
      chk1("t5_busy_terr", timeout_err, 1'b0);
    end
    step(); s_if.mem_ready = 1; s_if.mem_rdata = 32'h55; settle();
    chk1("t5_err_ready", m0_if.mem_ready, 1'b1);
    chk32("t5_err_rdata", m0_if.mem_rdata, 32'hDEAD_BEEF);
    chk1("t5_err_terr", timeout_err, 1'b1);
    chk1("t5_err_s_valid", s_if.mem_valid, 1'b0);
    chk1("t5_err_m1_ready", m1_if.mem_ready, 1'b0);
    step(); s_if.mem_ready = 0; m0_if.mem_valid = 0; settle();
    chk1("t5_terr_pulse", timeout_err, 1'b0);
    chk1("t5_ready_pulse", m0_if.mem_ready, 1'b0);

    // 5b: ready on the 8th BUSY cycle still completes normally
    step(); m0_if.mem_valid = 1; settle();
    for (int i = 0; i < 7; i++) begin
      step(); settle();
    end
    step(); s_if.mem_ready = 1; s_if.mem_rdata = 32'hA5A5_A5A5; settle();
    chk1("t5b_ready", m0_if.mem_ready, 1'b1);
    chk32("t5b_rdata", m0_if.mem_rdata, 32'hA5A5_A5A5);
    chk1("t5b_terr", timeout_err, 1'b0);
    step(); s_if.mem_ready = 0; m0_if.mem_valid = 0; settle();
    chk1("t5b_terr_after", timeout_err, 1'b0);
    chk1("t5b_s_valid_after", s_if.mem_valid, 1'b0);

    // 6: reset during BUSY with m1 granted
    step(); m1_if.mem_valid = 1; m1_if.mem_addr = 32'h400; settle();
    step(); settle();
    chk1("t6_grant_m1", grant, 1'b1);
    chk1("t6_s_valid_busy", s_if.mem_valid, 1'b1);
    step(); s_if.mem_ready = 1; reset = 1; m0_if.mem_valid = 1; m0_if.mem_addr = 32'h500;
    settle();
    chk1("t6_rst_s_valid", s_if.mem_valid, 1'b0);
    chk32("t6_rst_s_addr", s_if.mem_addr, 32'h0);
    chk1("t6_rst_grant", grant, 1'b0);
    chk1("t6_rst_m1_ready", m1_if.mem_ready, 1'b0);
    chk1("t6_rst_m0_ready", m0_if.mem_ready, 1'b0);
    chk1("t6_rst_terr", timeout_err, 1'b0);
    step(); reset = 0; s_if.mem_ready = 0; settle();
    chk1("t6_idle_s_valid", s_if.mem_valid, 1'b0);
    step(); settle();
    chk1("t6_grant_m0", grant, 1'b0);
    chk32("t6_s_addr_m0", s_if.mem_addr, 32'h500);
    step(); s_if.mem_ready = 1; settle();
    chk1("t6_m0_ready", m0_if.mem_ready, 1'b1);
    step(); s_if.mem_ready = 0; m0_if.mem_valid = 0; m1_if.mem_valid = 0;

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
